// File: rtl/ren_tile_emitter_if.sv
// Bbox-in / tile-out bundle for ren_tile_emitter.
// Master drives the bbox and the FIFO-full status; slave (the emitter) drives the rest.
// No storage; the handshakes are carried by the emitter itself.
interface ren_tile_emitter_if #(
  parameter int CW = 16
);
  logic          i_valid;
  logic [CW-1:0] i_min_x;
  logic [CW-1:0] i_min_y;
  logic [CW-1:0] i_max_x;
  logic [CW-1:0] i_max_y;
  logic          o_ready;
  logic          i_fifo_full_r;
  logic          o_fifo_write;
  logic [CW-1:0] o_tile_x;
  logic [CW-1:0] o_tile_y;
  logic [7:0]    o_tile_size;
  logic          o_busy;
  logic          o_done;

  modport master (
    output i_valid, i_min_x, i_min_y, i_max_x, i_max_y, i_fifo_full_r,
    input  o_ready, o_fifo_write, o_tile_x, o_tile_y, o_tile_size, o_busy, o_done
  );

  modport slave (
    input  i_valid, i_min_x, i_min_y, i_max_x, i_max_y, i_fifo_full_r,
    output o_ready, o_fifo_write, o_tile_x, o_tile_y, o_tile_size, o_busy, o_done
  );
endinterface

// File: rtl/ren_tile_emitter.sv
// Clamps a triangle bbox to the screen and emits every covered tile in raster order (x fastest).
// Latency: accept at T0, setup T0+1, first tile write T0+2, then one tile per cycle; done pulse after the last.
// Backpressure: a full raster FIFO or i_en low stalls the walk with position and outputs held.
module ren_tile_emitter #(
  parameter int SCREEN_W  = 640,
  parameter int SCREEN_H  = 480,
  parameter int TILE_SIZE = 16,
  parameter int CW        = 16
) (
  input  logic clk,
  input  logic rstn,
  input  logic i_en,
  ren_tile_emitter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_EMIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [CW-1:0] XLIM  = CW'(SCREEN_W - 1);
  localparam logic [CW-1:0] YLIM  = CW'(SCREEN_H - 1);
  localparam logic [CW-1:0] TSTEP = CW'(TILE_SIZE);
  localparam logic [CW-1:0] AMASK = ~CW'(TILE_SIZE - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] min_x_q, min_x_d, min_y_q, min_y_d;
  logic [CW-1:0] max_x_q, max_x_d, max_y_q, max_y_d;
  logic [CW-1:0] sx_q, sx_d, sy_q, sy_d, ex_q, ex_d, ey_q, ey_d;
  logic [CW-1:0] cur_x_q, cur_x_d, cur_y_q, cur_y_d;

  logic [CW-1:0] cmax_x, cmax_y;
  logic          box_empty;
  logic          accept;
  logic          write;
  logic          last_x, last_y;

  // Clamp, emptiness and handshake qualifiers shared by the FSM and datapath.
  always_comb begin
    cmax_x    = (max_x_q > XLIM) ? XLIM : max_x_q;
    cmax_y    = (max_y_q > YLIM) ? YLIM : max_y_q;
    box_empty = (min_x_q > cmax_x) || (min_y_q > cmax_y);
    accept    = (state_q == S_IDLE) && i_en && bus.i_valid;
    write     = (state_q == S_EMIT) && i_en && !bus.i_fifo_full_r;
    last_x    = (cur_x_q == ex_q);
    last_y    = (cur_y_q == ey_q);
  end

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; nothing moves while the block is disabled.
  always_comb begin
    state_d = state_q;
    if (i_en) begin
      unique case (state_q)
        S_IDLE:  if (bus.i_valid) state_d = S_SETUP;
        S_SETUP: state_d = box_empty ? S_DONE : S_EMIT;
        S_EMIT:  if (write && last_x && last_y) state_d = S_DONE;
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs decoded from state; tile coordinates come straight from the walk registers.
  always_comb begin
    bus.o_ready      = (state_q == S_IDLE) && i_en;
    bus.o_busy       = (state_q != S_IDLE);
    bus.o_fifo_write = write;
    bus.o_done       = (state_q == S_DONE) && i_en;
    bus.o_tile_x     = cur_x_q;
    bus.o_tile_y     = cur_y_q;
    bus.o_tile_size  = 8'(TILE_SIZE);
  end

  // Datapath next state: capture bbox, derive aligned bounds, step the raster walk.
  always_comb begin
    min_x_d = min_x_q;
    min_y_d = min_y_q;
    max_x_d = max_x_q;
    max_y_d = max_y_q;
    sx_d    = sx_q;
    sy_d    = sy_q;
    ex_d    = ex_q;
    ey_d    = ey_q;
    cur_x_d = cur_x_q;
    cur_y_d = cur_y_q;
    if (accept) begin
      min_x_d = bus.i_min_x;
      min_y_d = bus.i_min_y;
      max_x_d = bus.i_max_x;
      max_y_d = bus.i_max_y;
    end
    if ((state_q == S_SETUP) && i_en && !box_empty) begin
      sx_d    = min_x_q & AMASK;
      sy_d    = min_y_q & AMASK;
      ex_d    = cmax_x & AMASK;
      ey_d    = cmax_y & AMASK;
      cur_x_d = min_x_q & AMASK;
      cur_y_d = min_y_q & AMASK;
    end
    if (write) begin
      if (!last_x) begin
        cur_x_d = cur_x_q + TSTEP;
      end else if (!last_y) begin
        cur_x_d = sx_q;
        cur_y_d = cur_y_q + TSTEP;
      end
    end
  end

  // Datapath registers; reset discards any partial walk.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      min_x_q <= '0;
      min_y_q <= '0;
      max_x_q <= '0;
      max_y_q <= '0;
      sx_q    <= '0;
      sy_q    <= '0;
      ex_q    <= '0;
      ey_q    <= '0;
      cur_x_q <= '0;
      cur_y_q <= '0;
    end else begin
      min_x_q <= min_x_d;
      min_y_q <= min_y_d;
      max_x_q <= max_x_d;
      max_y_q <= max_y_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      ex_q    <= ex_d;
      ey_q    <= ey_d;
      cur_x_q <= cur_x_d;
      cur_y_q <= cur_y_d;
    end
  end

endmodule

// File: tb/tb_ren_tile_emitter.sv
// Bench for ren_tile_emitter: directed cases plus random bboxes under random stalls,
// checked against a tile-list reference built from the bbox with plain integer loops.
module tb_ren_tile_emitter;
  localparam int CW = 16;
  localparam int TS = 16;
  localparam int SW = 640;
  localparam int SH = 480;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  logic en   = 1'b0;

  always #5 clk = ~clk;

  ren_tile_emitter_if #(.CW(CW)) bus ();

  ren_tile_emitter #(
    .SCREEN_W(SW), .SCREEN_H(SH), .TILE_SIZE(TS), .CW(CW)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .i_en(en),
    .bus(bus)
  );

  int n_assert = 0;
  int n_fail   = 0;

  int exp_x[$], exp_y[$], got_x[$], got_y[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: every tile origin whose tile intersects the screen-clamped bbox, row by row.
  function automatic void model(input int mnx, input int mny, input int mxx, input int mxy);
    int cx, cy;
    exp_x.delete();
    exp_y.delete();
    cx = (mxx < SW) ? mxx : SW - 1;
    cy = (mxy < SH) ? mxy : SH - 1;
    if (mnx > cx || mny > cy) return;
    for (int y = (mny / TS) * TS; y <= cy; y += TS)
      for (int x = (mnx / TS) * TS; x <= cx; x += TS) begin
        exp_x.push_back(x);
        exp_y.push_back(y);
      end
  endfunction

  // Offer one bbox, collect writes until o_done, compare with the reference.
  // stall_after/stall_len/stall_en force a fixed stall (full or disable) after a given write.
  task automatic run_box(input int mnx, input int mny, input int mxx, input int mxy,
                         input int full_pct, input int en_pct,
                         input int stall_after, input int stall_len, input bit stall_en,
                         input string tag, output int w_off, output int d_off);
    int  cyc = 0;
    int  acc = -1;
    int  nw = 0;
    int  stall_left = 0;
    bit  stall_used = 0;
    bit  done = 0;
    model(mnx, mny, mxx, mxy);
    got_x.delete();
    got_y.delete();
    w_off = -1;
    d_off = -1;
    bus.i_valid = 1'b1;
    bus.i_min_x = CW'(mnx);
    bus.i_min_y = CW'(mny);
    bus.i_max_x = CW'(mxx);
    bus.i_max_y = CW'(mxy);
    bus.i_fifo_full_r = 1'b0;
    en = 1'b1;
    while (!done && cyc < 6000) begin
      @(negedge clk);
      if (acc < 0) begin
        if (bus.o_ready) acc = cyc;
      end else begin
        if (stall_left > 0) begin
          check({tag, "_stall_wr"}, bus.o_fifo_write, 0);
          if (nw < exp_x.size()) begin
            check({tag, "_hold_x"}, bus.o_tile_x, exp_x[nw]);
            check({tag, "_hold_y"}, bus.o_tile_y, exp_y[nw]);
          end
          stall_left--;
        end
        if (!en) begin
          check({tag, "_dis_wr"}, bus.o_fifo_write, 0);
          check({tag, "_dis_done"}, bus.o_done, 0);
        end
        if (bus.i_fifo_full_r) check({tag, "_full_wr"}, bus.o_fifo_write, 0);
        if (bus.o_fifo_write) begin
          got_x.push_back(int'(bus.o_tile_x));
          got_y.push_back(int'(bus.o_tile_y));
          check({tag, "_size"}, bus.o_tile_size, TS);
          if (w_off < 0) w_off = cyc - acc;
          nw++;
          if (nw == stall_after && !stall_used) begin
            stall_left = stall_len;
            stall_used = 1'b1;
          end
        end
        if (bus.o_done) begin
          d_off = cyc - acc;
          done  = 1'b1;
        end
      end
      @(posedge clk);
      #1;
      cyc++;
      if (acc >= 0) begin
        bus.i_valid = 1'b0;
        if (done) begin
          en = 1'b1;
          bus.i_fifo_full_r = 1'b0;
        end else if (stall_left > 0) begin
          en = !stall_en;
          bus.i_fifo_full_r = !stall_en;
        end else begin
          en = ($urandom_range(0, 99) >= en_pct);
          bus.i_fifo_full_r = ($urandom_range(0, 99) < full_pct);
        end
      end
    end
    if (!done) check({tag, "_timeout"}, 0, 1);
    check({tag, "_count"}, got_x.size(), exp_x.size());
    for (int i = 0; i < exp_x.size() && i < got_x.size(); i++) begin
      check({tag, "_tx"}, got_x[i], exp_x[i]);
      check({tag, "_ty"}, got_y[i], exp_y[i]);
    end
    @(negedge clk);
    check({tag, "_ready_after"}, bus.o_ready, 1);
    check({tag, "_busy_after"}, bus.o_busy, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, d, nw, mnx, mny, mxx, mxy;
    bit acc;
    int mx[6];
    int my[6];
    mx = '{0, 16, 32, 0, 16, 32};
    my = '{0, 0, 0, 16, 16, 16};
    bus.i_valid = 1'b0;
    bus.i_min_x = '0;
    bus.i_min_y = '0;
    bus.i_max_x = '0;
    bus.i_max_y = '0;
    bus.i_fifo_full_r = 1'b0;
    en = 1'b1;

    // Reset state.
    @(negedge clk);
    check("rst_busy", bus.o_busy, 0);
    check("rst_wr", bus.o_fifo_write, 0);
    check("rst_done", bus.o_done, 0);
    check("rst_tx", bus.o_tile_x, 0);
    check("rst_ty", bus.o_tile_y, 0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    @(negedge clk);
    check("rel_ready", bus.o_ready, 1);
    @(posedge clk);
    #1;

    // Single tile: write at T0+2, done at T0+3.
    run_box(3, 5, 10, 12, 0, 0, 0, 0, 1'b0, "single", w, d);
    check("single_wtime", w, 2);
    check("single_dtime", d, 3);
    check("single_x", got_x.size() > 0 ? got_x[0] : -1, 0);

    // Multi-tile raster order against literal tile list.
    run_box(10, 10, 40, 20, 0, 0, 0, 0, 1'b0, "multi", w, d);
    check("multi_n", got_x.size(), 6);
    for (int i = 0; i < 6 && i < got_x.size(); i++) begin
      check("multi_lx", got_x[i], mx[i]);
      check("multi_ly", got_y[i], my[i]);
    end
    check("multi_dtime", d, 8);

    // FIFO full for 3 cycles after the second write.
    run_box(10, 10, 40, 20, 0, 0, 2, 3, 1'b0, "bp", w, d);
    check("bp_n", got_x.size(), 6);
    check("bp_dtime", d, 11);

    // Screen clamp at the bottom-right corner.
    run_box(600, 470, 700, 500, 0, 0, 0, 0, 1'b0, "clamp", w, d);
    check("clamp_n", got_x.size(), 3);
    check("clamp_x0", got_x.size() > 0 ? got_x[0] : -1, 592);
    check("clamp_y0", got_y.size() > 0 ? got_y[0] : -1, 464);
    check("clamp_dtime", d, 5);

    // Empty: beyond screen, then swapped corners.
    run_box(700, 0, 800, 10, 0, 0, 0, 0, 1'b0, "offscr", w, d);
    check("offscr_n", got_x.size(), 0);
    check("offscr_dtime", d, 2);
    run_box(50, 50, 40, 60, 0, 0, 0, 0, 1'b0, "swap", w, d);
    check("swap_n", got_x.size(), 0);
    check("swap_dtime", d, 2);

    // i_en low for 4 cycles mid-walk.
    run_box(10, 10, 40, 20, 0, 0, 2, 4, 1'b1, "enlow", w, d);
    check("enlow_n", got_x.size(), 6);
    check("enlow_dtime", d, 12);

    // Reset during the third write of the multi-tile walk.
    bus.i_valid = 1'b1;
    bus.i_min_x = 16'd10;
    bus.i_min_y = 16'd10;
    bus.i_max_x = 16'd40;
    bus.i_max_y = 16'd20;
    en = 1'b1;
    nw = 0;
    acc = 1'b0;
    for (int c = 0; c < 50 && nw < 3; c++) begin
      @(negedge clk);
      if (!acc && bus.o_ready) acc = 1'b1;
      else if (bus.o_fifo_write) nw++;
      if (nw < 3) begin
        @(posedge clk);
        #1;
        if (acc) bus.i_valid = 1'b0;
      end
    end
    check("rmid_reached", nw, 3);
    check("rmid_tx_before", bus.o_tile_x, 32);
    rstn = 1'b0;
    #1;
    check("rmid_wr", bus.o_fifo_write, 0);
    check("rmid_busy", bus.o_busy, 0);
    check("rmid_done", bus.o_done, 0);
    check("rmid_tx", bus.o_tile_x, 0);
    check("rmid_ty", bus.o_tile_y, 0);
    bus.i_valid = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    @(negedge clk);
    check("rmid_ready", bus.o_ready, 1);
    @(posedge clk);
    #1;
    run_box(20, 20, 20, 20, 0, 0, 0, 0, 1'b0, "fresh", w, d);
    check("fresh_dtime", d, 3);

    // Random bboxes under random backpressure and disables.
    for (int k = 0; k < 25; k++) begin
      mnx = $urandom_range(0, 700);
      mny = $urandom_range(0, 520);
      if ($urandom_range(0, 9) == 0) begin
        mxx = mnx - $urandom_range(1, 40);
        mxy = mny + $urandom_range(0, 100);
      end else begin
        mxx = mnx + $urandom_range(0, 150);
        mxy = mny + $urandom_range(0, 150);
      end
      if (mxx < 0) mxx = 0;
      run_box(mnx, mny, mxx, mxy, 30, 15, 0, 0, 1'b0, "rand", w, d);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
